// File: rtl/stud_sample_fifo.sv
// stud_sample_fifo
//   Sample buffer between the host write path and the modulator. Host samples
//   enter through a valid/ready handshake into a circular FIFO. Each
//   single-cycle audio_rd_i strobe releases one sample to audio_data_o.
//   Reads stay gated until the FIFO is half full. An empty read while running
//   sets a sticky underrun flag and drops back to prefill.
//
//   Build option: STUD_FIFO_HOLD_LAST_EN
//     defined   - an underrun or a strobe during prefill holds the last sample
//                 on audio_data_o, which avoids a step to zero (click)
//     undefined - audio_data_o goes to 0 in those cases
//
//   Ports
//     clk_i          system clock, rising edge
//     rst_i          synchronous reset, active-high
//     wr_data_i      sample from host
//     wr_valid_i     wr_data_i valid
//     wr_ready_o     FIFO can accept a sample
//     audio_rd_i     one-cycle read strobe from the oversampling generator
//     audio_data_o   registered sample to the modulator
//     level_o        number of stored samples
//     running_o      1 = RUN, 0 = FILL
//     underrun_o     sticky underrun flag
//     clr_underrun_i clears underrun_o (a new underrun wins)
//
//   state | meaning
//   FILL  | prefilling; strobes do not pop; leaves once level >= depth/2
//   RUN   | each strobe pops one sample; an empty strobe returns to FILL
module stud_sample_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic                  audio_rd_i,
    output logic [WIDTH-1:0]      audio_data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  running_o,
    output logic                  underrun_o,
    input  logic                  clr_underrun_i
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int HALF  = 2 ** (DEPTH_LOG2 - 1);
    localparam logic [DEPTH_LOG2:0] HALF_LVL = HALF[DEPTH_LOG2:0];

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [0:0]          r_state;
    logic [WIDTH-1:0]    r_audio_data;
    logic                r_underrun;

    logic [DEPTH_LOG2:0] w_level;
    logic                w_empty;
    logic                w_full;
    logic                w_wr_ready;
    logic                w_wr_en;
    logic                w_pop;
    logic                w_underrun;

    // Extra MSB on each pointer distinguishes full from empty.
    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                        (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    // Ready comes from registered pointers only: a pop in this cycle does not
    // free a slot until the next cycle.
    assign w_wr_ready = !w_full && !rst_i;
    assign w_wr_en    = wr_valid_i && w_wr_ready;
    assign w_pop      = audio_rd_i && (r_state == ST_RUN) && !w_empty;
    assign w_underrun = audio_rd_i && (r_state == ST_RUN) && w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_state      <= ST_FILL;
            r_audio_data <= '0;
            r_underrun   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_audio_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
            end
`ifdef STUD_FIFO_HOLD_LAST_EN
`else
            // Strobe without a pop: prefill strobe or underrun.
            else if (audio_rd_i) begin
                r_audio_data <= '0;
            end
`endif

            case (r_state)
                ST_FILL: if (w_level >= HALF_LVL) r_state <= ST_RUN;
                ST_RUN:  if (w_underrun)          r_state <= ST_FILL;
                default:                          r_state <= ST_FILL;
            endcase

            if (w_underrun) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun_i) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Sample storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data_i;
        end
    end

    assign wr_ready_o   = w_wr_ready;
    assign audio_data_o = r_audio_data;
    assign level_o      = rst_i ? '0 : w_level;
    assign running_o    = (r_state == ST_RUN) && !rst_i;
    assign underrun_o   = r_underrun;

endmodule

// File: doc/stud_sample_fifo.md
Name: stud_sample_fifo

Overview:
Sample buffer on the write side of the audio-read strobe interface. Accepts PCM samples from the host/register side through a valid/ready handshake and stores them in a circular FIFO. Releases exactly one sample to the modulator datapath per single-cycle audio_rd_i strobe from the oversampling strobe generator. Adds prefill gating and sticky underrun reporting.

Parameters:
WIDTH, 16, sample width in bits (two's complement, passed through unmodified)
DEPTH_LOG2, 3, log2 of FIFO depth (depth = 2^DEPTH_LOG2, legal range 2..8)

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
wr_data_i  input  WIDTH  sample from host
wr_valid_i  input  1  wr_data_i valid
wr_ready_o  output  1  FIFO can accept; write occurs when wr_valid_i && wr_ready_o
audio_rd_i  input  1  one-cycle read strobe, one per sample period
audio_data_o  output  WIDTH  current sample to modulator, registered
level_o  output  DEPTH_LOG2+1  number of stored samples, 0..2^DEPTH_LOG2
running_o  output  1  1 = RUN state, 0 = FILL state
underrun_o  output  1  sticky underrun flag
clr_underrun_i  input  1  clears underrun_o

Behaviour:
- Storage: 2^DEPTH_LOG2 x WIDTH array, not reset. Read and write pointers are DEPTH_LOG2+1 bits, with the MSB as the wrap bit. Empty when pointers are equal. Full when the low bits are equal and the MSBs differ. Pointers wrap modulo 2^(DEPTH_LOG2+1).
- level_o = wr_ptr - rd_ptr, computed modulo 2^(DEPTH_LOG2+1) from the registered pointers.
- wr_ready_o = !full && !rst_i, decoded from the registered pointers. There is no same-cycle pass-through of a pop into ready.
- An accepted write stores wr_data_i at wr_ptr and increments wr_ptr on the same edge.
- State machine: FILL (reset state) and RUN.
  - FILL -> RUN on the edge where the registered level is >= 2^(DEPTH_LOG2-1) (half full).
  - RUN -> FILL on an underrun.
- audio_rd_i in FILL: no pop, audio_data_o <= 0, underrun not flagged.
- audio_rd_i in RUN, FIFO not empty: audio_data_o <= mem[rd_ptr] and rd_ptr increments, both on the edge where the strobe is sampled. The new value is visible the following cycle.
- audio_rd_i in RUN, FIFO empty (underrun):
  - no pop;
  - underrun_o <= 1;
  - state <= FILL;
  - audio_data_o <= 0 (see Optional Feature).
- audio_data_o holds its value between strobes.
- Simultaneous write and pop: both are performed and the level is unchanged.
- Write while empty, with a strobe in the same cycle: there is no bypass. The strobe is an underrun and the written sample is stored.
- Full, with a strobe in the same cycle: wr_ready_o is still 0 that cycle, so no write is accepted. Ready rises the next cycle.
- Strobe held high for N cycles: treated as N reads. The source guarantees single-cycle pulses.
- underrun_o: set has priority over clr_underrun_i in the same cycle. It is cleared only by clr_underrun_i or reset.
- Reset, including mid-operation: on the first edge with rst_i = 1, the following take effect, and stored data is discarded:
  - pointers = 0;
  - state = FILL;
  - audio_data_o = 0;
  - underrun_o = 0;
  - level_o = 0, running_o = 0, wr_ready_o = 0 while rst_i is high.
- wr_ready_o = 1 on the first cycle after rst_i is released.

Optional Feature:
Macro STUD_FIFO_HOLD_LAST_EN.
- Defined: on an underrun, and on a strobe in FILL, audio_data_o keeps its previous value. This avoids a step to zero and the resulting click. Reset still clears audio_data_o to 0.
- Undefined: audio_data_o <= 0 in those cases, as described under Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Default parameters for all scenarios: WIDTH=16, DEPTH_LOG2=3.
- Prefill: write 0x0001..0x0003, then strobe -> audio_data_o = 0x0000, running_o = 0, level_o = 3. Write 0x0004 -> running_o = 1 one cycle later. Strobe -> audio_data_o = 0x0001 the next cycle, level_o = 3.
- Full/backpressure: hold wr_valid_i high with 8 distinct samples and no strobes -> level_o = 8, wr_ready_o = 0. The 9th sample is not accepted. Issue a strobe -> wr_ready_o = 1 one cycle after the pop, and the 9th sample is accepted.
- Underrun: prefill 4, issue 5 strobes spaced 32 cycles apart -> outputs are the 4 samples in order. The 5th strobe gives underrun_o = 1, running_o = 0, audio_data_o = 0x0000, or the 4th sample held when STUD_FIFO_HOLD_LAST_EN is defined.
- Simultaneous events:
  - Write and strobe in the same cycle in RUN with level 5 -> level_o stays 5.
  - clr_underrun_i asserted in the same cycle as a new underrun -> underrun_o stays 1.
  - clr_underrun_i asserted alone -> underrun_o = 0 next cycle.
- Wrap-around: stream 100 incrementing samples with writes and strobes interleaved (strobe every 32 cycles, writes keeping level between 4 and 8) -> output sequence matches the input sequence exactly, with no underrun.
- Reset mid-operation: with level_o = 6 in RUN, pulse rst_i for 1 cycle -> level_o = 0, running_o = 0, audio_data_o = 0, underrun_o = 0, wr_ready_o = 1 on the cycle after release.
